// File: rtl/nervous_alarm_manager.sv
// Alarm manager: persistence-filters the detector code, latches peak severity, drives a pulsed buzzer until acknowledged.
// Optional NERVOUS_AUTO_CLEAR_EN: a stable 00 code in ALARM returns directly to IDLE.
module nervous_alarm_manager #(
  parameter int unsigned PERSIST     = 3,
  parameter int unsigned BEEP_PERIOD = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       nervousAbnormality,
  input  logic             ack,
  output logic [1:0]       alarm_level,
  output logic             alarm_active,
  output logic             buzzer,
  output logic [CNT_W-1:0] event_count
);

  localparam int unsigned PW = $clog2(PERSIST + 1);
  localparam int unsigned BW = (BEEP_PERIOD > 1) ? $clog2(BEEP_PERIOD) : 1;
  localparam logic [PW-1:0]    PERSIST_V = PW'(PERSIST);
  localparam logic [BW-1:0]    BEEP_LAST = BW'(BEEP_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALARM = 2'd1,
    ACKED = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [1:0]       cand;
  logic [PW-1:0]    fcnt;
  logic [BW-1:0]    beep, beep_d;
  logic [1:0]       level_d;
  logic             buzzer_d;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_inc;
  logic             filt_valid;
  logic [1:0]       filt_level;
  logic             esc;

  // Persistence filter: a code counts once it has been sampled PERSIST times in a row.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cand <= 2'b00;
      fcnt <= PERSIST_V;
    end else if (nervousAbnormality == cand) begin
      if (fcnt != PERSIST_V) fcnt <= fcnt + PW'(1);
    end else begin
      cand <= nervousAbnormality;
      fcnt <= PW'(1);
    end
  end

  assign filt_valid = (fcnt == PERSIST_V);
  assign filt_level = cand;
  assign esc        = filt_valid && (filt_level > alarm_level);
  assign count_inc  = (event_count == CNT_MAX) ? event_count : event_count + CNT_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      alarm_level  <= 2'b00;
      alarm_active <= 1'b0;
      buzzer       <= 1'b0;
      beep         <= '0;
      event_count  <= '0;
    end else begin
      state        <= state_d;
      alarm_level  <= level_d;
      alarm_active <= (state_d != IDLE);
      buzzer       <= buzzer_d;
      beep         <= beep_d;
      event_count  <= count_d;
    end
  end

  always_comb begin
    state_d  = state;
    level_d  = alarm_level;
    buzzer_d = buzzer;
    beep_d   = beep;
    count_d  = event_count;
    case (state)
      IDLE: begin
        level_d  = 2'b00;
        buzzer_d = 1'b0;
        beep_d   = '0;
        if (filt_valid && (filt_level != 2'b00)) begin
          state_d  = ALARM;
          level_d  = filt_level;
          buzzer_d = 1'b1;
          count_d  = count_inc;
        end
      end
      ALARM: begin
        // Escalation outranks acknowledge in the same cycle.
        if (esc) begin
          level_d  = filt_level;
          buzzer_d = 1'b1;
          beep_d   = '0;
          count_d  = count_inc;
`ifdef NERVOUS_AUTO_CLEAR_EN
        end else if (filt_valid && (filt_level == 2'b00)) begin
          state_d  = IDLE;
          level_d  = 2'b00;
          buzzer_d = 1'b0;
          beep_d   = '0;
`endif
        end else if (ack) begin
          state_d  = ACKED;
          buzzer_d = 1'b0;
          beep_d   = '0;
        end else if (beep == BEEP_LAST) begin
          buzzer_d = ~buzzer;
          beep_d   = '0;
        end else begin
          beep_d = beep + BW'(1);
        end
      end
      ACKED: begin
        buzzer_d = 1'b0;
        beep_d   = '0;
        if (esc) begin
          state_d  = ALARM;
          level_d  = filt_level;
          buzzer_d = 1'b1;
          count_d  = count_inc;
        end else if (filt_valid && (filt_level == 2'b00)) begin
          state_d = IDLE;
          level_d = 2'b00;
        end
      end
      default: begin
        state_d  = IDLE;
        level_d  = 2'b00;
        buzzer_d = 1'b0;
        beep_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_nervous_alarm_manager.sv
// Randomized bench for nervous_alarm_manager against a sample-history / elapsed-time reference model.
module tb_nervous_alarm_manager;

  localparam int unsigned P  = 3;
  localparam int unsigned BP = 4;

  localparam int M_IDLE  = 0;
  localparam int M_ALARM = 1;
  localparam int M_ACKED = 2;

  logic       clock;
  logic       reset;
  logic [1:0] code;
  logic       ack;
  logic [1:0] alarm_level;
  logic       alarm_active;
  logic       buzzer;
  logic [7:0] event_count;
  logic [1:0] sat_level;
  logic       sat_active;
  logic       sat_buzzer;
  logic [1:0] sat_count;

  int checks = 0;
  int errors = 0;

  nervous_alarm_manager #(.PERSIST(P), .BEEP_PERIOD(BP), .CNT_W(8)) u_dut (
    .clock(clock), .reset(reset), .nervousAbnormality(code), .ack(ack),
    .alarm_level(alarm_level), .alarm_active(alarm_active), .buzzer(buzzer),
    .event_count(event_count)
  );

  nervous_alarm_manager #(.PERSIST(P), .BEEP_PERIOD(BP), .CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .nervousAbnormality(code), .ack(ack),
    .alarm_level(sat_level), .alarm_active(sat_active), .buzzer(sat_buzzer),
    .event_count(sat_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: last P sampled codes, alarm mode, peak level, raw event total, buzzer start edge.
  bit [1:0] hist[$];
  int       m_state;
  int       m_level;
  int       raw;
  int       cyc;
  int       t0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, want, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < int'(P); i++) hist.push_back(2'b00);
    m_state = M_IDLE;
    m_level = 0;
    raw     = 0;
    t0      = 0;
  endtask

  task automatic start_alarm(input int lvl);
    m_state = M_ALARM;
    m_level = lvl;
    raw++;
    t0 = cyc;
  endtask

  task automatic model_edge(input bit [1:0] c, input bit a);
    bit fv;
    int fl;
    bit esc;
    cyc++;
    fv = 1'b1;
    foreach (hist[i]) if (hist[i] != hist[0]) fv = 1'b0;
    fl  = int'(hist[P-1]);
    esc = fv && (fl > m_level);
    case (m_state)
      M_IDLE: if (fv && fl != 0) start_alarm(fl);
      M_ALARM: begin
        if (esc) start_alarm(fl);
`ifdef NERVOUS_AUTO_CLEAR_EN
        else if (fv && fl == 0) begin m_state = M_IDLE; m_level = 0; end
`endif
        else if (a) m_state = M_ACKED;
      end
      default: begin
        if (esc) start_alarm(fl);
        else if (fv && fl == 0) begin m_state = M_IDLE; m_level = 0; end
      end
    endcase
    hist.push_back(c);
    void'(hist.pop_front());
  endtask

  task automatic compare_all();
    int exp_buz;
    exp_buz = (m_state == M_ALARM && (((cyc - t0) / int'(BP)) % 2 == 0)) ? 1 : 0;
    check("alarm_level",  32'(alarm_level),  32'(m_level));
    check("alarm_active", 32'(alarm_active), (m_state != M_IDLE) ? 32'd1 : 32'd0);
    check("buzzer",       32'(buzzer),       32'(exp_buz));
    check("event_count",  32'(event_count),  (raw > 255) ? 32'd255 : 32'(raw));
    check("event_count_sat", 32'(sat_count), (raw > 3) ? 32'd3 : 32'(raw));
  endtask

  task automatic step(input logic [1:0] c, input logic a);
    code = c;
    ack  = a;
    @(posedge clock);
    model_edge(c, a);
    #1;
    compare_all();
  endtask

  task automatic hold(input logic [1:0] c, input int n);
    for (int i = 0; i < n; i++) step(c, 1'b0);
  endtask

  // Reset asserted between edges; outputs must clear before any further edge.
  task automatic mid_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("reset_buzzer_sat", 32'(sat_buzzer), 32'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    code  = 2'b00;
    ack   = 1'b0;
    cyc   = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    compare_all();
    @(negedge clock);
    reset = 1'b0;

    // Glitch of two samples is rejected.
    hold(2'b01, 2);
    hold(2'b00, 4);

    // Basic alarm and buzzer square wave.
    hold(2'b10, 4);
    hold(2'b10, 12);

    // Ack, then stable 00 returns to idle.
    step(2'b10, 1'b1);
    hold(2'b10, 3);
    hold(2'b00, 5);

    // Escalation 01 -> 11, then a lower stable level is ignored.
    hold(2'b01, 6);
    hold(2'b11, 5);
    hold(2'b01, 6);
    step(2'b01, 1'b1);
    hold(2'b00, 5);

    // Ack on the same edge the filtered level rises 10 -> 11.
    hold(2'b10, 6);
    hold(2'b11, 3);
    step(2'b11, 1'b1);
    hold(2'b11, 3);
    mid_reset();

    // Five separate events saturate the 2-bit counter.
    for (int k = 0; k < 5; k++) begin
      hold(2'b01, 4);
      step(2'b01, 1'b1);
      hold(2'b00, 5);
    end

    // Stable 00 while still in ALARM (auto-clear builds leave immediately).
    hold(2'b10, 5);
    hold(2'b00, 5);
    step(2'b00, 1'b1);
    hold(2'b00, 4);
    mid_reset();

    // Randomized segments of held codes with sporadic ack and resets.
    for (int s = 0; s < 60; s++) begin
      logic [1:0] c;
      int len;
      c   = 2'($urandom_range(0, 3));
      len = int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) step(c, ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 29) == 0) mid_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
